// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: debounced hex decoder for a scanned 7-segment bus with one-hot digit strobe.
// Define SEG7_READER_BLANK_EN to add digit_blank reporting for the all-off pattern.
module seg7_scan_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    changed,
    output logic                    bad_pattern,
    output logic                    sel_err
`ifdef SEG7_READER_BLANK_EN
    ,
    output logic [NUM_DIGITS-1:0]   digit_blank
`endif
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] ST = 4'(STABLE_CNT);

    logic [6:0]              r_last [NUM_DIGITS];
    logic [3:0]              r_cnt  [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic                    r_changed, r_bad, r_sel_err;

    logic [IW-1:0] w_idx;
    logic          w_sample, w_multi, w_same, w_commit, w_hit, w_blank, w_blank_diff;
    logic [3:0]    w_nib, w_cur_nib, w_new_nib, w_cnt_nxt;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1111110: decode = 5'h10;
            7'b1100000: decode = 5'h11;
            7'b1011101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b1100011: decode = 5'h14;
            7'b0111011: decode = 5'h15;
            7'b0111111: decode = 5'h16;
            7'b1101000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1111011: decode = 5'h19;
            7'b1101111: decode = 5'h1A;
            7'b0110111: decode = 5'h1B;
            7'b0011110: decode = 5'h1C;
            7'b1110101: decode = 5'h1D;
            7'b0011111: decode = 5'h1E;
            7'b0001111: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

`ifdef SEG7_READER_BLANK_EN
    logic [NUM_DIGITS-1:0] r_blank;
`endif

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (dig_sel[k]) w_idx = IW'(k);
        w_sample  = $onehot(dig_sel);
        w_multi   = dig_sel != '0 && !w_sample;
        w_same    = seg_in == r_last[w_idx];
        w_cnt_nxt = !w_same ? 4'd1 : (r_cnt[w_idx] == ST ? ST : r_cnt[w_idx] + 4'd1);
        // A saturated run re-sampled with the same pattern must not commit again
        w_commit  = w_sample && w_cnt_nxt == ST && !(w_same && r_cnt[w_idx] == ST);
        {w_hit, w_nib} = decode(seg_in);
        w_cur_nib = r_value[w_idx*4 +: 4];
        w_new_nib = w_hit ? w_nib : w_cur_nib;
`ifdef SEG7_READER_BLANK_EN
        w_blank      = seg_in == 7'b0;
        w_blank_diff = w_blank != r_blank[w_idx];
`else
        w_blank      = 1'b0;
        w_blank_diff = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_last[k] <= 7'b0;
                r_cnt[k]  <= 4'd0;
            end
            r_value   <= '0;
            r_valid   <= '0;
            r_changed <= 1'b0;
            r_bad     <= 1'b0;
            r_sel_err <= 1'b0;
        end else begin
            r_changed <= w_commit && (w_new_nib != w_cur_nib || w_hit != r_valid[w_idx] || w_blank_diff);
            r_bad     <= w_commit && !w_hit && !w_blank;
            r_sel_err <= w_multi;
            if (w_sample) begin
                r_last[w_idx] <= seg_in;
                r_cnt[w_idx]  <= w_cnt_nxt;
            end
            if (w_commit) begin
                r_value[w_idx*4 +: 4] <= w_new_nib;
                r_valid[w_idx]        <= w_hit;
            end
        end
    end

`ifdef SEG7_READER_BLANK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blank <= '0;
        else if (w_commit)
            r_blank[w_idx] <= w_blank;
    end

    assign digit_blank = r_blank;
`endif

    assign value       = r_value;
    assign digit_valid = r_valid;
    assign changed     = r_changed;
    assign bad_pattern = r_bad;
    assign sel_err     = r_sel_err;
endmodule
